// File: rtl/i2c_arbiter_pkg.sv
// Purpose: shared types and constants for the two-requester I2C master arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package i2c_arbiter_pkg;

  // Transaction sequencer states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } arb_state_t;

  // Per-requester cfg field {aen, ac[1:0], dc[1:0]}
  localparam int CFG_W     = 5;
  localparam int CFG_AEN   = 4;
  localparam int CFG_AC_HI = 3;
  localparam int CFG_AC_LO = 2;
  localparam int CFG_DC_HI = 1;
  localparam int CFG_DC_LO = 0;

  localparam int TIMEOUT_CYC_DEF = 100000;
  localparam int ISSUE_WAIT_DEF  = 4;

  // Wait counter width; saturates instead of wrapping
  localparam int TMO_W = 20;

  // Latched copy of the granted request, drives the master for the whole transaction
  typedef struct packed {
    logic             rw;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [6:0]       sa;
    logic [CFG_W-1:0] cfg;
  } hold_t;

  // Slice one requester's fields out of the packed request buses
  function automatic hold_t pick_req(
    input logic        idx,
    input logic [1:0]  rw,
    input logic [63:0] addr,
    input logic [63:0] wdata,
    input logic [13:0] sa,
    input logic [9:0]  cfg
  );
    hold_t h;
    h.rw    = idx ? rw[1]        : rw[0];
    h.addr  = idx ? addr[63:32]  : addr[31:0];
    h.wdata = idx ? wdata[63:32] : wdata[31:0];
    h.sa    = idx ? sa[13:7]     : sa[6:0];
    h.cfg   = idx ? cfg[9:5]     : cfg[4:0];
    return h;
  endfunction

endpackage

// File: rtl/i2c_arbiter_rr_arb2.sv
// Purpose: two-way round-robin picker; when both request, the one not granted last wins.
// Latency: purely combinational, same cycle.
// Backpressure: none; caller decides whether the pick is consumed.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       any,
  output logic       gnt_idx
);

  // Lone requester wins outright; a tie goes to the requester that was not granted last
  always_comb begin
    any     = |req;
    gnt_idx = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = ~last_grant;
    end else if (req[1]) begin
      gnt_idx = 1'b1;
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Purpose: shares one I2C master between two requesters, one transaction at a time.
// Latency: grant to rsp_valid is at least 4 cycles; 5-cycle minimum grant-to-grant turnaround.
// Backpressure: requests wait in IDLE while busy or while m_stall is still high; not cancellable.
module i2c_arbiter
  import i2c_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int ISSUE_WAIT  = ISSUE_WAIT_DEF
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_rw,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [13:0] req_sa,
  input  logic [9:0]  req_cfg,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        m_valid,
  output logic        m_rw,
  output logic [31:0] m_addr,
  output logic [31:0] m_wr_data,
  output logic [6:0]  m_slave_addr,
  output logic        m_i2aen,
  output logic [1:0]  m_i2ac,
  output logic [1:0]  m_i2dc,
  input  logic        m_stall,
  input  logic        m_rd_valid,
  input  logic [31:0] m_rd_data
);

  // WAIT_BUSY gives up on its (ISSUE_WAIT-1)th cycle so the error response lands
  // exactly ISSUE_WAIT cycles after the m_valid pulse.
  localparam logic [TMO_W-1:0] BUSY_LIM =
    (ISSUE_WAIT >= 2) ? TMO_W'(ISSUE_WAIT - 2) : '0;
  // WAIT_DONE gives up after TIMEOUT_CYC cycles spent stalled.
  localparam logic [TMO_W-1:0] DONE_LIM =
    (TIMEOUT_CYC >= 1) ? TMO_W'(TIMEOUT_CYC - 1) : '0;

  arb_state_t       state;
  hold_t            hold;
  logic             last_grant;
  logic             owner;
  logic [TMO_W-1:0] cnt;
  logic [TMO_W-1:0] cnt_inc;
  logic [31:0]      rdata;
  logic             arb_any;
  logic             arb_idx;
  logic             rd_cap;

  rr_arb2 u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .any        (arb_any),
    .gnt_idx    (arb_idx)
  );

  // Saturating increment so a very long stall can never wrap back under the limit
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

  // Read data is only meaningful for reads; write completions report zero
  assign rd_cap = m_rd_valid && !hold.rw;

  // Master-facing fields come straight from the hold registers; the master samples
  // i2aen/i2ac/i2dc live, so these must not move until the next grant.
  assign m_rw         = hold.rw;
  assign m_addr       = hold.addr;
  assign m_wr_data    = hold.wdata;
  assign m_slave_addr = hold.sa;
  assign m_i2aen      = hold.cfg[CFG_AEN];
  assign m_i2ac       = hold.cfg[CFG_AC_HI:CFG_AC_LO];
  assign m_i2dc       = hold.cfg[CFG_DC_HI:CFG_DC_LO];

  // Transaction sequencer with registered handshake and response outputs
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      hold       <= '0;
      cnt        <= '0;
      rdata      <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      m_valid    <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      m_valid   <= 1'b0;
      cnt       <= cnt_inc;
      case (state)
        IDLE: begin
          // A master still stalled from an aborted transaction blocks new grants
          if (arb_any && !m_stall) begin
            hold               <= pick_req(arb_idx, req_rw, req_addr, req_wdata, req_sa, req_cfg);
            owner              <= arb_idx;
            last_grant         <= arb_idx;
            rdata              <= '0;
            req_ready[arb_idx] <= 1'b1;
            m_valid            <= 1'b1;
            state              <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (m_stall) begin
            cnt   <= '0;
            state <= WAIT_DONE;
          end else if (cnt >= BUSY_LIM) begin
            // Master never picked the transaction up
            rdata            <= '0;
            rsp_rdata        <= '0;
            rsp_err          <= 1'b1;
            rsp_valid[owner] <= 1'b1;
            state            <= RESP;
          end
        end
        WAIT_DONE: begin
          if (!m_stall) begin
            rdata            <= rd_cap ? m_rd_data : rdata;
            rsp_rdata        <= rd_cap ? m_rd_data : rdata;
            rsp_err          <= 1'b0;
            rsp_valid[owner] <= 1'b1;
            state            <= RESP;
          end else if (cnt >= DONE_LIM) begin
            // Abort without touching the master; it keeps stalling until it recovers
            rdata            <= '0;
            rsp_rdata        <= '0;
            rsp_err          <= 1'b1;
            rsp_valid[owner] <= 1'b1;
            state            <= RESP;
          end else if (rd_cap) begin
            rdata <= m_rd_data;
          end
        end
        RESP: begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
